// File: rtl/cipher_arbiter_if.sv
// Requester, grant and cipher-core handshake bundle for cipher_arbiter.
// master = requesters plus core model side, slave = the arbiter.
interface cipher_arbiter_if;
  logic         req0, req1;
  logic [127:0] data0, data1;
  logic         gnt0, gnt1;
  logic         done0, done1;
  logic [127:0] result;
  logic         err;
  logic         enc_start;
  logic [127:0] enc_plain;
  logic         enc_end;
  logic [0:127] enc_cipher;

  modport master (
    output req0, req1, data0, data1, enc_end, enc_cipher,
    input  gnt0, gnt1, done0, done1, result, err, enc_start, enc_plain
  );

  modport slave (
    input  req0, req1, data0, data1, enc_end, enc_cipher,
    output gnt0, gnt1, done0, done1, result, err, enc_start, enc_plain
  );
endinterface

// File: rtl/cipher_arbiter.sv
// Two-requester round-robin front end for a slow cipher core with a
// return-to-zero start/end handshake. Optional RUN timeout: CIPHER_TIMEOUT_EN.
module cipher_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  cipher_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, DRAIN} state_t;

  state_t       state;
  logic [1:0]   end_sync;
  logic         end_s;
  logic         ptr;
  logic         owner;
  logic         pick;
  logic [127:0] cipher_rev;
  logic         gnt0_q, gnt1_q, done0_q, done1_q, start_q;
  logic [127:0] plain_q, result_q;

  // enc_end comes from the divided core clock domain
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) end_sync <= 2'b00;
    else            end_sync <= {end_sync[0], bus.enc_end};
  end
  assign end_s = end_sync[1];

  // core bit k (MSB-first numbering) lands at result bit 127-k
  for (genvar k = 0; k < 128; k++) begin : g_rev
    assign cipher_rev[127-k] = bus.enc_cipher[k];
  end

  // ptr=1 favours requester 1 when both are asking
  always_comb begin
    pick = bus.req1 & (~bus.req0 | ptr);
  end

`ifdef CIPHER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;
  logic          err_q;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      start_q  <= 1'b0;
      plain_q  <= '0;
      result_q <= '0;
`ifdef CIPHER_TIMEOUT_EN
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
`ifdef CIPHER_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // a core still asserting end from a previous job blocks new work
          if ((bus.req0 | bus.req1) && !end_s) begin
            owner   <= pick;
            gnt0_q  <= ~pick;
            gnt1_q  <= pick;
            plain_q <= pick ? bus.data1 : bus.data0;
            start_q <= 1'b1;
            state   <= RUN;
`ifdef CIPHER_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        RUN: begin
          if (end_s) begin
            result_q <= cipher_rev;
            state    <= DONE;
          end
`ifdef CIPHER_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            start_q <= 1'b0;
            ptr     <= ~owner;
            state   <= DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          done0_q <= ~owner;
          done1_q <= owner;
          start_q <= 1'b0;
          ptr     <= ~owner;
          state   <= DRAIN;
        end
        DRAIN: begin
          if (!end_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.enc_start = start_q;
  assign bus.enc_plain = plain_q;
  assign bus.result    = result_q;

`ifdef CIPHER_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif
endmodule

// File: tb/tb_cipher_arbiter.sv
// Bench for cipher_arbiter: vector table of request patterns plus reset,
// ghost-request, long-latency and (with CIPHER_TIMEOUT_EN) timeout sequences.
module tb_cipher_arbiter;
  localparam int TMO = 16;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  cipher_arbiter_if bus();
  cipher_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus)
  );

  typedef struct {
    logic         who;
    logic [127:0] plain;
    logic [127:0] res;
    int           req_cyc;
    logic         chk_lat;
  } exp_t;

  typedef struct {
    logic         r0;
    logic         r1;
    logic [127:0] d0;
    logic [127:0] d1;
    int           lat;
    int           hold;
    logic         first;
  } vec_t;

  exp_t gq[$];
  exp_t dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = -100;
  int err_cyc = -1;
  int ghost = 0;
  int core_lat = 4;
  int core_hold = 0;
  logic core_mute = 1'b0;
  logic [127:0] res_hold;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // stand-in for the cipher core's transform
  function automatic logic [127:0] core_fn(input logic [127:0] p);
    return {p[63:0], p[127:64]} ^ 128'hA5A5_0F0F_3C3C_C3C3_5A5A_F0F0_1234_8765;
  endfunction

  // result[127-k] = core bit k, core bus numbered [0:127]
  function automatic logic [127:0] rev_model(input logic [0:127] c);
    logic [127:0] r;
    for (int k = 0; k < 128; k++) r[127-k] = c[k];
    return r;
  endfunction

  function automatic int lat_cap(input int l);
`ifdef CIPHER_TIMEOUT_EN
    return (l > 8) ? 8 : l;
`else
    return l;
`endif
  endfunction

  task automatic expect_txn(input logic who, input logic [127:0] d, input logic lat_chk);
    exp_t e;
    e.who = who; e.plain = d; e.res = rev_model(core_fn(d));
    e.req_cyc = cyc; e.chk_lat = lat_chk;
    gq.push_back(e);
    dq.push_back(e);
  endtask

  task automatic service(input int budget);
    int n = 0;
    while ((dq.size() != 0 || gq.size() != 0 || bus.req0 || bus.req1) && n < budget) begin
      @(negedge sys_clk);
      n++;
      if (bus.gnt0) bus.req0 = 1'b0;
      if (bus.gnt1) bus.req1 = 1'b0;
    end
    checki("service_in_budget", int'(n < budget), 1);
    n = 0;
    while (bus.enc_end && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (5) @(negedge sys_clk);
  endtask

  // core model: answers enc_start after core_lat cycles, releases after core_hold
  initial begin : core
    logic [127:0] p;
    int n;
    bus.enc_end = 1'b0;
    bus.enc_cipher = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && bus.enc_start && !core_mute) begin
        p = bus.enc_plain;
        n = 0;
        while (n < core_lat && bus.enc_start) begin
          @(negedge sys_clk);
          n++;
        end
        if (bus.enc_start) begin
          bus.enc_cipher = core_fn(p);
          bus.enc_end = 1'b1;
          rise_cyc = cyc;
          n = 0;
          while (bus.enc_start && n < 200) begin
            @(negedge sys_clk);
            n++;
          end
          repeat (core_hold) @(negedge sys_clk);
          bus.enc_end = 1'b0;
          bus.enc_cipher = {$urandom(), $urandom(), $urandom(), $urandom()};
          fall_cyc = cyc;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin : mon
    exp_t e;
    res_hold = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        dq.delete();
        res_hold = '0;
      end else begin
        checki("gnt_excl", int'(bus.gnt0 & bus.gnt1), 0);
        checki("done_excl", int'(bus.done0 & bus.done1), 0);
        checki("err", int'(bus.err), int'(cyc == err_cyc));
        if (bus.gnt0 || bus.gnt1) begin
          if (gq.size() == 0) ghost++;
          else begin
            e = gq.pop_front();
            checki("gnt_who", int'(bus.gnt1), int'(e.who));
            check("enc_plain", bus.enc_plain, e.plain);
            checki("enc_start_at_gnt", int'(bus.enc_start), 1);
            check("result_hold", bus.result, res_hold);
            if (e.chk_lat) checki("gnt_lat", cyc - e.req_cyc, 1);
            checki("gnt_after_drain", int'(cyc >= fall_cyc + 4), 1);
          end
        end
        if (bus.done0 || bus.done1) begin
          if (dq.size() == 0) ghost++;
          else begin
            e = dq.pop_front();
            checki("done_who", int'(bus.done1), int'(e.who));
            check("result", bus.result, e.res);
            checki("done_lat", cyc - rise_cyc, 4);
            checki("enc_start_at_done", int'(bus.enc_start), 0);
            res_hold = e.res;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_all_zero(input string tag);
    checki({tag, "_gnt"}, int'(bus.gnt0 | bus.gnt1), 0);
    checki({tag, "_done"}, int'(bus.done0 | bus.done1), 0);
    checki({tag, "_err"}, int'(bus.err), 0);
    checki({tag, "_start"}, int'(bus.enc_start), 0);
    check({tag, "_result"}, bus.result, 128'h0);
    check({tag, "_plain"}, bus.enc_plain, 128'h0);
  endtask

  initial begin : drv
    vec_t vt[7];
    exp_t e;
    logic [127:0] da;
    vt[0] = '{1'b1, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
              128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 5, 0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003,
              128'hCAFE_F00D_0000_0004_0000_0005_0000_0006, 3, 2, 1'b0};
    vt[2] = '{1'b1, 1'b1, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F,
              128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F1, 2, 10, 1'b0};
    vt[3] = '{1'b0, 1'b1, 128'h0, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 7, 1, 1'b1};
    vt[4] = '{1'b1, 1'b0, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 128'h0, 40, 0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 128'h1234_5678_9ABC_DEF0_1357_9BDF_2468_ACE0,
              128'hFEDC_BA98_7654_3210_FFFF_0000_FFFF_0000, 4, 0, 1'b1};
    vt[6] = '{1'b1, 1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0, 0, 3, 1'b0};

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = '0; bus.data1 = '0;

    repeat (2) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checki("idle_quiet", int'(bus.gnt0 | bus.gnt1 | bus.enc_start), 0);

    for (int i = 0; i < 7; i++) begin
      core_lat = lat_cap(vt[i].lat);
      core_hold = vt[i].hold;
      @(negedge sys_clk);
      bus.data0 = vt[i].d0; bus.data1 = vt[i].d1;
      bus.req0 = vt[i].r0; bus.req1 = vt[i].r1;
      if (vt[i].r0 && vt[i].r1) begin
        expect_txn(vt[i].first, vt[i].first ? vt[i].d1 : vt[i].d0, 1'b1);
        expect_txn(!vt[i].first, vt[i].first ? vt[i].d0 : vt[i].d1, 1'b0);
      end else begin
        expect_txn(vt[i].r1, vt[i].r1 ? vt[i].d1 : vt[i].d0, 1'b1);
      end
      service(vt[i].lat + 300);
    end

    // short req1 pulse during a running job must never be granted
    core_lat = 8; core_hold = 0;
    @(negedge sys_clk);
    bus.data0 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA; bus.req0 = 1'b1;
    expect_txn(1'b0, bus.data0, 1'b1);
    @(negedge sys_clk);
    bus.req0 = 1'b0;
    repeat (2) @(negedge sys_clk);
    bus.data1 = 128'h7777_7777_7777_7777_7777_7777_7777_7777; bus.req1 = 1'b1;
    repeat (2) @(negedge sys_clk);
    bus.req1 = 1'b0;
    service(300);
    checki("ghost_after_drop", ghost, 0);

    // reset in the middle of RUN, then a fresh request after release
    core_lat = lat_cap(30); core_hold = 0;
    @(negedge sys_clk);
    bus.data0 = 128'hABCD_0000_0000_0000_0000_0000_0000_1234; bus.req0 = 1'b1;
    expect_txn(1'b0, bus.data0, 1'b1);
    @(negedge sys_clk);
    bus.req0 = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge sys_clk);
    da = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    bus.data0 = da; bus.req0 = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    expect_txn(1'b0, da, 1'b1);
    service(300);

`ifndef CIPHER_TIMEOUT_EN
    // very slow core: RUN waits, no err
    core_lat = 3000; core_hold = 0;
    @(negedge sys_clk);
    bus.data0 = 128'h0BAD_CAFE_0BAD_CAFE_0BAD_CAFE_0BAD_CAFE; bus.req0 = 1'b1;
    expect_txn(1'b0, bus.data0, 1'b1);
    service(3400);
`else
    // silent core: err pulse 16 cycles after gnt, no done, pointer still flips
    core_mute = 1'b1; core_lat = 4; core_hold = 0;
    @(negedge sys_clk);
    bus.data0 = 128'h7E57_0000_0000_0000_0000_0000_0000_0001; bus.req0 = 1'b1;
    e.who = 1'b0; e.plain = bus.data0; e.res = '0; e.req_cyc = cyc; e.chk_lat = 1'b1;
    gq.push_back(e);
    err_cyc = cyc + 1 + TMO;
    service(50);
    while (cyc < err_cyc + 2) @(negedge sys_clk);
    checki("tmo_start_low", int'(bus.enc_start), 0);
    core_mute = 1'b0;
    @(negedge sys_clk);
    bus.data0 = 128'h1111_0000_0000_0000_0000_0000_0000_0000;
    bus.data1 = 128'h2222_0000_0000_0000_0000_0000_0000_0000;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    expect_txn(1'b1, bus.data1, 1'b1);
    expect_txn(1'b0, bus.data0, 1'b0);
    service(300);
`endif

    checki("ghost_total", ghost, 0);
    checki("scoreboard_empty", gq.size() + dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
